// File: rtl/prgm_sched_pkg.sv
// Shared types and constants for the program-memory scheduler and its arbiter.
package prgm_sched_pkg;

    localparam int DEF_AW         = 6;
    localparam int DEF_DW         = 8;
    localparam int DEF_READ_WAIT  = 2;
    localparam int DEF_WRITE_HOLD = 3;
    localparam int DEF_ERASE_HOLD = 4;

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_RD    = 3'd1,
        ST_WR    = 3'd2,
        ST_ERASE = 3'd3,
        ST_ACK   = 3'd4,
        ST_CDONE = 3'd5
    } sched_state_t;

    typedef enum logic {
        REQ_LD = 1'b0,
        REQ_FE = 1'b1
    } req_id_t;

    function automatic int max3(input int a, input int b, input int c);
        int m;
        m = a;
        if (b > m) m = b;
        if (c > m) m = c;
        return m;
    endfunction

endpackage

// File: rtl/prgm_mem_sched_rr_arb2.sv
// Two-input round-robin arbiter: loader vs fetch, with a last-grant flop so
// that competing requesters alternate.
module rr_arb2
    import prgm_sched_pkg::*;
(
    input  logic    clk,
    input  logic    rst_n,
    input  logic    ld_req,
    input  logic    fe_req,
    input  logic    take,
    output req_id_t grant,
    output logic    valid
);

    req_id_t last_grant;

    // Pick the requester that was not served last when both compete.
    always_comb begin
        valid = ld_req | fe_req;
        if (ld_req && fe_req) begin
            grant = (last_grant == REQ_LD) ? REQ_FE : REQ_LD;
        end else if (fe_req) begin
            grant = REQ_FE;
        end else begin
            grant = REQ_LD;
        end
    end

    // Remember the winner of every accepted grant; reset favours the loader.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant <= REQ_FE;
        end else if (take && valid) begin
            last_grant <= grant;
        end
    end

endmodule

// File: rtl/prgm_mem_sched.sv
// Scheduler for the single-port program memory: arbitrates loader and fetch
// requests, times reads, writes and whole-memory clears, and drives the
// memory pins from registers so they are glitch-free.
module prgm_mem_sched
    import prgm_sched_pkg::*;
#(
    parameter int AW         = DEF_AW,
    parameter int DW         = DEF_DW,
    parameter int READ_WAIT  = DEF_READ_WAIT,
    parameter int WRITE_HOLD = DEF_WRITE_HOLD,
    parameter int ERASE_HOLD = DEF_ERASE_HOLD
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          ld_req,
    input  logic          ld_we,
    input  logic [AW-1:0] ld_adrs,
    input  logic [DW-1:0] ld_wdata,
    output logic          ld_ack,
    input  logic          fe_req,
    input  logic          fe_we,
    input  logic [AW-1:0] fe_adrs,
    input  logic [DW-1:0] fe_wdata,
    output logic          fe_ack,
    output logic [DW-1:0] rdata,
    input  logic          clr_req,
    output logic          clr_done,
    output logic          busy,
    output logic [AW-1:0] mem_adrs,
    output logic [DW-1:0] mem_data,
    output logic          mem_mode,
    output logic          mem_erase,
    input  logic [DW-1:0] mem_out
);

    localparam int CW = $clog2(max3(READ_WAIT, WRITE_HOLD, ERASE_HOLD)) + 1;
    localparam logic [CW-1:0] READ_LOAD  = CW'(READ_WAIT - 1);
    localparam logic [CW-1:0] WRITE_LOAD = CW'(WRITE_HOLD - 1);
    localparam logic [CW-1:0] ERASE_LOAD = CW'(ERASE_HOLD - 1);

    sched_state_t  state;
    logic [CW-1:0] cnt;
    req_id_t       owner;

    req_id_t       arb_grant;
    logic          arb_valid;
    logic          arb_take;

    logic          sel_we;
    logic [AW-1:0] sel_adrs;
    logic [DW-1:0] sel_wdata;

    // A grant is only consumed in IDLE when no clear is pending.
    assign arb_take = (state == ST_IDLE) && !clr_req;

    rr_arb2 u_arb (
        .clk    (clk),
        .rst_n  (rst_n),
        .ld_req (ld_req),
        .fe_req (fe_req),
        .take   (arb_take),
        .grant  (arb_grant),
        .valid  (arb_valid)
    );

    // Route the winning requester's operation, address and data to the capture registers.
    always_comb begin
        sel_we    = ld_we;
        sel_adrs  = ld_adrs;
        sel_wdata = ld_wdata;
        if (arb_grant == REQ_FE) begin
            sel_we    = fe_we;
            sel_adrs  = fe_adrs;
            sel_wdata = fe_wdata;
        end
    end

    // Main sequencer: arbitration, timed memory access, clear, and registered handshakes.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= ST_IDLE;
            cnt       <= '0;
            owner     <= REQ_LD;
            rdata     <= '0;
            mem_adrs  <= '0;
            mem_data  <= '0;
            mem_mode  <= 1'b0;
            mem_erase <= 1'b0;
            ld_ack    <= 1'b0;
            fe_ack    <= 1'b0;
            clr_done  <= 1'b0;
            busy      <= 1'b0;
        end else begin
            ld_ack   <= 1'b0;
            fe_ack   <= 1'b0;
            clr_done <= 1'b0;
            case (state)
                ST_IDLE: begin
                    if (clr_req) begin
                        state     <= ST_ERASE;
                        cnt       <= ERASE_LOAD;
                        mem_mode  <= 1'b0;
                        mem_erase <= 1'b1;
                        busy      <= 1'b1;
                    end else if (arb_valid) begin
                        owner    <= arb_grant;
                        mem_adrs <= sel_adrs;
                        mem_data <= sel_wdata;
                        busy     <= 1'b1;
                        if (sel_we) begin
                            state    <= ST_WR;
                            cnt      <= WRITE_LOAD;
                            mem_mode <= 1'b1;
                        end else begin
                            state    <= ST_RD;
                            cnt      <= READ_LOAD;
                            mem_mode <= 1'b0;
                        end
                    end else begin
                        busy <= 1'b0;
                    end
                end
                ST_RD: begin
                    if (cnt == '0) begin
                        rdata  <= mem_out;
                        state  <= ST_ACK;
                        ld_ack <= (owner == REQ_LD);
                        fe_ack <= (owner == REQ_FE);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_WR: begin
                    if (cnt == '0) begin
                        mem_mode <= 1'b0;
                        state    <= ST_ACK;
                        ld_ack   <= (owner == REQ_LD);
                        fe_ack   <= (owner == REQ_FE);
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ERASE: begin
                    if (cnt == '0) begin
                        mem_erase <= 1'b0;
                        state     <= ST_CDONE;
                        clr_done  <= 1'b1;
                    end else begin
                        cnt <= cnt - 1'b1;
                    end
                end
                ST_ACK: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                ST_CDONE: begin
                    state <= ST_IDLE;
                    busy  <= 1'b0;
                end
                default: begin
                    state     <= ST_IDLE;
                    mem_mode  <= 1'b0;
                    mem_erase <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_prgm_mem_sched.sv
// Self-checking bench for prgm_mem_sched: a behavioural program memory sits on
// the memory pins, and a shadow array plus a round-robin preference bit give
// the expected read data, grant order and handshake timing.
module tb_prgm_mem_sched;

    localparam int RW = 2;
    localparam int WH = 3;
    localparam int EH = 4;

    logic       clk;
    logic       rst_n;
    logic       ld_req, ld_we, fe_req, fe_we, clr_req;
    logic [5:0] ld_adrs, fe_adrs;
    logic [7:0] ld_wdata, fe_wdata;
    logic       ld_ack, fe_ack, clr_done, busy;
    logic [7:0] rdata;
    logic [5:0] mem_adrs;
    logic [7:0] mem_data, mem_out;
    logic       mem_mode, mem_erase;

    logic [7:0] mem_array [64];
    logic [7:0] ref_mem   [64];
    bit         rr_next;
    int         total;
    int         bad;

    prgm_mem_sched dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .ld_req    (ld_req),
        .ld_we     (ld_we),
        .ld_adrs   (ld_adrs),
        .ld_wdata  (ld_wdata),
        .ld_ack    (ld_ack),
        .fe_req    (fe_req),
        .fe_we     (fe_we),
        .fe_adrs   (fe_adrs),
        .fe_wdata  (fe_wdata),
        .fe_ack    (fe_ack),
        .rdata     (rdata),
        .clr_req   (clr_req),
        .clr_done  (clr_done),
        .busy      (busy),
        .mem_adrs  (mem_adrs),
        .mem_data  (mem_data),
        .mem_mode  (mem_mode),
        .mem_erase (mem_erase),
        .mem_out   (mem_out)
    );

    // Free-running clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Behavioural single-port program memory: erase wins, write on mode, async read.
    always @(posedge clk) begin
        if (mem_erase) begin
            for (int i = 0; i < 64; i++) mem_array[i] <= 8'h00;
        end else if (mem_mode) begin
            mem_array[mem_adrs] <= mem_data;
        end
    end
    assign mem_out = mem_array[mem_adrs];

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic checkOutput(input string tag, input int obs, input int exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("[TB] FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic applyStimulus(input bit who, input bit we, input logic [5:0] a, input logic [7:0] d);
        if (!who) begin
            ld_req = 1'b1; ld_we = we; ld_adrs = a; ld_wdata = d;
        end else begin
            fe_req = 1'b1; fe_we = we; fe_adrs = a; fe_wdata = d;
        end
    endtask

    task automatic dropReq();
        ld_req = 1'b0;
        fe_req = 1'b0;
    endtask

    task automatic clearModel();
        for (int i = 0; i < 64; i++) ref_mem[i] = 8'h00;
    endtask

    // One transaction from IDLE; optional mid-read disturbance and clear request.
    task automatic runOp(input string tag, input bit who, input bit we, input logic [5:0] a,
                         input logic [7:0] d, input bit disturb, input bit raise_clr);
        int  lat = 0;
        int  mode_cyc = 0;
        int  erase_cyc = 0;
        int  wrong_ack = 0;
        bit  got = 1'b0;
        bit  adrs_ok = 1'b1;
        applyStimulus(who, we, a, d);
        for (int k = 1; k <= 40; k++) begin
            tick();
            lat = k;
            if (mem_mode) mode_cyc++;
            if (mem_erase) erase_cyc++;
            if (mem_adrs !== a) adrs_ok = 1'b0;
            if (who ? ld_ack : fe_ack) wrong_ack++;
            if (k == 1) begin
                if (raise_clr) clr_req = 1'b1;
                if (disturb) begin
                    dropReq();
                    ld_adrs = 6'd9; fe_adrs = 6'd9;
                    ld_we = ~we; fe_we = ~we;
                    ld_wdata = ~d; fe_wdata = ~d;
                end
            end
            if (who ? fe_ack : ld_ack) begin
                got = 1'b1;
                break;
            end
        end
        dropReq();
        checkOutput($sformatf("%s ack", tag), int'(got), 1);
        checkOutput($sformatf("%s latency", tag), lat, we ? WH + 1 : RW + 1);
        checkOutput($sformatf("%s wrong_ack", tag), wrong_ack, 0);
        checkOutput($sformatf("%s erase_during_op", tag), erase_cyc, 0);
        checkOutput($sformatf("%s mem_adrs", tag), int'(adrs_ok), 1);
        if (we) begin
            checkOutput($sformatf("%s mode_cycles", tag), mode_cyc, WH);
            ref_mem[a] = d;
        end else begin
            checkOutput($sformatf("%s mode_cycles", tag), mode_cyc, 0);
            checkOutput($sformatf("%s rdata", tag), int'(rdata), int'(ref_mem[a]));
        end
        rr_next = ~who;
        tick();
        checkOutput($sformatf("%s idle_gap_busy", tag), int'(busy), 0);
        checkOutput($sformatf("%s ack_one_cycle", tag), int'(ld_ack | fe_ack), 0);
    endtask

    // Wait for a clear already requested; drop clr_req once erasing has started.
    task automatic waitClear(input string tag);
        int erase_cyc = 0;
        int overlap = 0;
        bit got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            tick();
            if (mem_erase) begin
                erase_cyc++;
                clr_req = 1'b0;
            end
            if (mem_erase && mem_mode) overlap++;
            if (clr_done) begin
                got = 1'b1;
                break;
            end
        end
        clr_req = 1'b0;
        checkOutput($sformatf("%s clr_done", tag), int'(got), 1);
        checkOutput($sformatf("%s erase_cycles", tag), erase_cyc, EH);
        checkOutput($sformatf("%s mode_erase_overlap", tag), overlap, 0);
        clearModel();
        tick();
        checkOutput($sformatf("%s idle_after_clear", tag), int'(busy | clr_done), 0);
    endtask

    initial begin
        logic [5:0] a;
        logic [7:0] d;
        total = 0;
        bad = 0;
        rr_next = 1'b0;
        clearModel();
        rst_n = 1'b0;
        ld_req = 0; ld_we = 0; ld_adrs = '0; ld_wdata = '0;
        fe_req = 0; fe_we = 0; fe_adrs = '0; fe_wdata = '0;
        clr_req = 0;

        // Reset state.
        repeat (3) tick();
        checkOutput("reset outputs",
                    int'({rdata, mem_adrs, mem_data, mem_mode, mem_erase, ld_ack, fe_ack, clr_done, busy}), 0);
        rst_n = 1'b1;
        tick();

        // Clear the memory so every address starts from a known value.
        clr_req = 1'b1;
        waitClear("init clear");

        // Loader write of 0xA3 to 5, then fetch read of 5.
        runOp("ld write 5", 1'b0, 1'b1, 6'd5, 8'hA3, 1'b0, 1'b0);
        runOp("fe read 5", 1'b1, 1'b0, 6'd5, 8'h00, 1'b0, 1'b0);
        checkOutput("fe read 5 value", int'(rdata), 8'hA3);

        // Both requesters held, reads of 1 and 2, four rounds.
        runOp("pre write 1", 1'b0, 1'b1, 6'd1, 8'($urandom), 1'b0, 1'b0);
        runOp("pre write 2", 1'b1, 1'b1, 6'd2, 8'($urandom), 1'b0, 1'b0);
        begin
            int acks = 0;
            int last_at = 0;
            int both = 0;
            bit who;
            applyStimulus(1'b0, 1'b0, 6'd1, 8'h00);
            applyStimulus(1'b1, 1'b0, 6'd2, 8'h00);
            for (int k = 1; k <= 80; k++) begin
                tick();
                if (ld_ack && fe_ack) both++;
                if (ld_ack || fe_ack) begin
                    who = fe_ack;
                    checkOutput($sformatf("rr grant %0d", acks), int'(who), int'(rr_next));
                    checkOutput($sformatf("rr rdata %0d", acks), int'(rdata), int'(ref_mem[who ? 2 : 1]));
                    if (acks > 0) checkOutput($sformatf("rr spacing %0d", acks), k - last_at, RW + 2);
                    last_at = k;
                    rr_next = ~who;
                    acks++;
                    if (acks == 4) begin
                        dropReq();
                        break;
                    end
                end
            end
            dropReq();
            checkOutput("rr ack count", acks, 4);
            checkOutput("rr double ack", both, 0);
            tick();
        end

        // Random mix of loader/fetch reads and writes.
        for (int n = 0; n < 10; n++) begin
            runOp($sformatf("rand op %0d", n), 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
                  6'($urandom_range(0, 63)), 8'($urandom), 1'b0, 1'b0);
        end

        // Clear arriving during a fetch read waits for the read to finish.
        a = 6'($urandom_range(0, 63));
        d = 8'($urandom) | 8'h01;
        runOp("clr pre write", 1'b0, 1'b1, a, d, 1'b0, 1'b0);
        runOp("clr during read", 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b1);
        checkOutput("clr during read value", int'(rdata), int'(d));
        waitClear("clr after read");
        runOp("read after clear", 1'b0, 1'b0, a, 8'h00, 1'b0, 1'b0);

        // Requester drops req and changes address mid-read.
        a = 6'($urandom_range(10, 63));
        d = 8'($urandom);
        runOp("dist write orig", 1'b0, 1'b1, a, d, 1'b0, 1'b0);
        runOp("dist write 9", 1'b1, 1'b1, 6'd9, ~d, 1'b0, 1'b0);
        runOp("disturbed read", 1'b1, 1'b0, a, 8'h00, 1'b1, 1'b0);

        // Asynchronous reset during the second cycle of a write.
        a = 6'($urandom_range(0, 63));
        applyStimulus(1'b0, 1'b1, a, 8'($urandom));
        tick();
        tick();
        checkOutput("rst pre mode", int'(mem_mode), 1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rst mode async", int'(mem_mode), 0);
        checkOutput("rst all outputs",
                    int'({rdata, mem_adrs, mem_data, mem_mode, mem_erase, ld_ack, fe_ack, clr_done, busy}), 0);
        dropReq();
        begin
            int acks = 0;
            for (int k = 0; k < 3; k++) begin
                tick();
                if (ld_ack || fe_ack) acks++;
            end
            checkOutput("rst no ack", acks, 0);
        end
        rst_n = 1'b1;
        rr_next = 1'b0;
        tick();
        d = 8'($urandom);
        runOp("post rst write", 1'b0, 1'b1, a, d, 1'b0, 1'b0);
        runOp("post rst read", 1'b1, 1'b0, a, 8'h00, 1'b0, 1'b0);

        // Clear held continuously starves both requesters.
        begin
            int pulses = 0;
            int last_at = 0;
            int acks = 0;
            int modes = 0;
            clr_req = 1'b1;
            applyStimulus(1'b0, 1'b0, 6'($urandom_range(0, 63)), 8'h00);
            applyStimulus(1'b1, 1'b1, 6'($urandom_range(0, 63)), 8'($urandom));
            for (int k = 1; k <= 100; k++) begin
                tick();
                if (ld_ack || fe_ack) acks++;
                if (mem_mode) modes++;
                if (clr_done) begin
                    if (pulses > 0) checkOutput($sformatf("clr period %0d", pulses), k - last_at, EH + 2);
                    last_at = k;
                    pulses++;
                    if (pulses == 3) break;
                end
            end
            clr_req = 1'b0;
            dropReq();
            clearModel();
            checkOutput("clr hold pulses", pulses, 3);
            checkOutput("clr hold starved acks", acks, 0);
            checkOutput("clr hold mode", modes, 0);
            tick();
            checkOutput("clr hold idle", int'(busy), 0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
